// File: rtl/pipelined_skip_adder_pkg.sv
// rtl/pipelined_skip_adder_pkg.sv - default geometry, stage control type, saturation limits
package skip_adder_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_BLOCK  = 4;
    localparam int unsigned DEF_STAGES = 2;

    // Saturation limits are built at this width and truncated by the user; WIDTH <= 128.
    localparam int unsigned SAT_W = 128;

    // Width-independent part of a stage register. Partial sum and pending operand
    // bits shrink/grow per stage, so they live beside this as sized vectors.
    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_ctl_t;

    function automatic int unsigned blocks_per_stage(input int unsigned width,
                                                     input int unsigned block,
                                                     input int unsigned stages);
        return (width / block) / stages;
    endfunction

    function automatic logic [SAT_W-1:0] sat_max(input int unsigned width);
        return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int unsigned width);
        return SAT_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/pipelined_skip_adder_if.sv
// rtl/pipelined_skip_adder_if.sv - operand/result handshake bundle for the skip adder
interface pipelined_skip_adder_if
    import skip_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_skip_adder_skip_block.sv
// rtl/pipelined_skip_adder_skip_block.sv - BLOCK-bit ripple group with propagate-AND bypass
module skip_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             all_prop
);
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic             c_run;
    logic             ripple_c;

    assign p        = a ^ b;
    assign g        = a & b;
    assign all_prop = &p;

    // Ripple through the group; sum bits always come from here.
    always_comb begin
        sum   = '0;
        c_run = cin;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i] = p[i] ^ c_run;
            c_run  = g[i] | (p[i] & c_run);
        end
        ripple_c = c_run;
    end

    // Bypass is selected from operand propagates only, so the skip path is never
    // gated by a sum bit that is itself waiting on the ripple.
    assign cout = all_prop ? cin : ripple_c;
endmodule

// File: rtl/pipelined_skip_adder.sv
// rtl/pipelined_skip_adder.sv - pipelined carry-skip add/sub; SKIP_ADDER_SAT_EN enables signed clamp
module pipelined_skip_adder
    import skip_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned BLOCK  = DEF_BLOCK,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_skip_adder_if.slave bus
);
    localparam int unsigned BPS  = blocks_per_stage(WIDTH, BLOCK, STAGES);
    localparam int unsigned GW   = BPS * BLOCK;
    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned LAST = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign cin_eff      = bus.sub | bus.cin;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned LO = s * GW;
        localparam int unsigned HI = LO + GW;

        stage_ctl_t       src_ctl;
        stage_ctl_t       ctl_d;
        stage_ctl_t       ctl_q;
        logic [WIDTH-1:LO] src_pa;
        logic [WIDTH-1:LO] src_pb;
        logic [HI-1:0]    psum_d;
        logic [HI-1:0]    psum_q;
        logic [GW-1:0]    grp_sum;
        logic [BPS-1:0]   bprop;
        logic             grp_cout;

        if (s == 0) begin : g_src
            assign src_ctl = '{valid: bus.in_valid, carry: cin_eff,
                               a_msb: bus.a[MSB], b_msb: b_eff[MSB]};
            assign src_pa  = bus.a;
            assign src_pb  = b_eff;
            assign psum_d  = grp_sum;
        end else begin : g_src
            assign src_ctl = g_stage[s-1].ctl_q;
            assign src_pa  = g_stage[s-1].g_pend.pa_q;
            assign src_pb  = g_stage[s-1].g_pend.pb_q;
            assign psum_d  = {grp_sum, g_stage[s-1].psum_q};
        end

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            logic c_in;
            logic c_out;
            if (j == 0) begin : g_cin
                assign c_in = src_ctl.carry;
            end else begin : g_cin
                assign c_in = g_blk[j-1].c_out;
            end
            skip_block #(.BLOCK(BLOCK)) u_blk (
                .a        (src_pa[LO + j*BLOCK +: BLOCK]),
                .b        (src_pb[LO + j*BLOCK +: BLOCK]),
                .cin      (c_in),
                .sum      (grp_sum[j*BLOCK +: BLOCK]),
                .cout     (c_out),
                .all_prop (bprop[j])
            );
        end

        // Second skip level across the whole group before the stage register.
        assign grp_cout = (&bprop) ? src_ctl.carry : g_blk[BPS-1].c_out;

        // Forward valid and sign bits untouched; replace the carry with this group's.
        always_comb begin
            ctl_d       = src_ctl;
            ctl_d.carry = grp_cout;
        end

        // Stage register: bubbles advance with adv just like valid beats.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q  <= '0;
                psum_q <= '0;
            end else if (adv) begin
                ctl_q  <= ctl_d;
                psum_q <= psum_d;
            end
        end

        if (s < LAST) begin : g_pend
            logic [WIDTH-1:HI] pa_q;
            logic [WIDTH-1:HI] pb_q;

            // Carry the not-yet-added operand bits (b already inverted for sub) upward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pa_q <= '0;
                    pb_q <= '0;
                end else if (adv) begin
                    pa_q <= src_pa[WIDTH-1:HI];
                    pb_q <= src_pb[WIDTH-1:HI];
                end
            end
        end
    end

    logic             ovf_w;
    logic [WIDTH-1:0] res_w;

    assign ovf_w = (g_stage[LAST].ctl_q.a_msb == g_stage[LAST].ctl_q.b_msb) &
                   (g_stage[LAST].psum_q[MSB] != g_stage[LAST].ctl_q.a_msb);

`ifdef SKIP_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

    assign res_w = ovf_w ? (g_stage[LAST].ctl_q.a_msb ? SAT_LO : SAT_HI)
                         : g_stage[LAST].psum_q;
`else
    assign res_w = g_stage[LAST].psum_q;
`endif

    assign bus.out_valid = g_stage[LAST].ctl_q.valid;
    assign bus.sum       = res_w;
    assign bus.cout      = g_stage[LAST].ctl_q.carry;
    assign bus.ovf       = ovf_w;
endmodule

// File: tb/tb_pipelined_skip_adder.sv
// tb/tb_pipelined_skip_adder.sv - self-checking bench for pipelined_skip_adder
module tb_pipelined_skip_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_skip_adder_if #(.WIDTH(32)) bus   ();
    pipelined_skip_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_skip_adder_if #(.WIDTH(64)) bus64 ();

    pipelined_skip_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipelined_skip_adder #(.WIDTH(16), .BLOCK(4), .STAGES(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    pipelined_skip_adder #(.WIDTH(64), .BLOCK(8), .STAGES(2)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

`ifdef SKIP_ADDER_SAT_EN
    localparam logic [31:0] EXP_SUB_OVF = 32'h8000_0000;
    localparam logic [31:0] EXP_ADD_OVF = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] EXP_SUB_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_ADD_OVF = 32'h8000_0000;
`endif

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide addition, {ovf, cout, sum}.
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                              input logic cin, input logic sub);
        logic [63:0] mask;
        logic [63:0] bp;
        logic [63:0] s;
        logic [64:0] r;
        logic        c;
        logic        ov;
        logic        am;
        logic        bm;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        bp   = (sub ? ~b : b) & mask;
        r    = {1'b0, a & mask} + {1'b0, bp} + {64'd0, (sub | cin)};
        c    = r[w];
        s    = r[63:0] & mask;
        am   = a[w-1];
        bm   = bp[w-1];
        ov   = (am == bm) && (s[w-1] != am);
`ifdef SKIP_ADDER_SAT_EN
        if (ov) s = am ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`endif
        return {ov, c, s};
    endfunction

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub,
                           input logic [31:0] es, input logic ec, input logic eo);
        int n;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_latency"}, 64'(n), 64'd2);
        check_val({tag, "_sum"}, 64'(bus.sum), 64'(es));
        check_val({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        check_val({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
        @(posedge clk); #1;
        check_val({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic        sc [8];
        logic        ss [8];
        logic [65:0] exp_q [$];
        logic [65:0] q16 [$];
        logic [65:0] q64 [$];
        logic [65:0] e;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic        rs;
        logic        v;
        logic        fire_in;
        logic        fire_out;
        int          sent;
        int          got;
        int          cyc;
        int          stale;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;   bus.out_ready = 1'b1; bus.a = '0;   bus.b = '0;   bus.cin = 1'b0;   bus.sub = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.a = '0; bus64.b = '0; bus64.cin = 1'b0; bus64.sub = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_sum", 64'(bus.sum), 64'd0);
        check_val("rst_cout", 64'(bus.cout), 64'd0);
        check_val("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors
        run_vec("add_carry16", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run_vec("full_prop",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_vec("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, EXP_SUB_OVF,   1'b1, 1'b1);
        run_vec("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, EXP_ADD_OVF,   1'b0, 1'b1);
        run_vec("sub_neg",     32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_vec("add_mixed",   32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0);
        run_vec("sub_cin_ign", 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Back-pressure: 8 beats, out_ready low in cycles 3..6
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom();
            sb[i] = $urandom();
            sc[i] = 1'($urandom_range(0, 1));
            ss[i] = 1'($urandom_range(0, 1));
        end
        sa[2] = 32'hFFFF_FFFF; sb[2] = 32'h0; sc[2] = 1'b1; ss[2] = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 60) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            bus.in_valid  = (sent < 8);
            if (sent < 8) begin
                bus.a = sa[sent]; bus.b = sb[sent]; bus.cin = sc[sent]; bus.sub = ss[sent];
            end
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                check_val("bp_in_ready_stalled", 64'(bus.in_ready), 64'd0);
                check_val("bp_out_valid_stalled", 64'(bus.out_valid), 64'd1);
            end
            fire_in  = bus.in_valid & bus.in_ready;
            fire_out = bus.out_valid & bus.out_ready;
            if (exp_q.size() == 0) begin
                check_val("bp_spurious", 64'(bus.out_valid), 64'd0);
            end else if (bus.out_valid) begin
                e = exp_q[0];
                check_val("bp_sum", 64'(bus.sum), e[63:0] & 64'hFFFF_FFFF);
                check_val("bp_cout", 64'(bus.cout), 64'(e[64]));
                check_val("bp_ovf", 64'(bus.ovf), 64'(e[65]));
            end
            if (fire_out && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            if (fire_in) begin
                exp_q.push_back(ref_model(32, 64'(bus.a), 64'(bus.b), bus.cin, bus.sub));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_val("bp_beats_out", 64'(got), 64'd8);
        check_val("bp_total_cycles", 64'(cyc), 64'd14);
        #1;
        check_val("bp_no_duplicate", 64'(bus.out_valid), 64'd0);

        // Reset mid-flight with two beats in the pipe
        bus.a = 32'd1; bus.b = 32'd2; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'd10; bus.b = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_val("rmf_pre_valid", 64'(bus.out_valid), 64'd1);
        check_val("rmf_pre_sum", 64'(bus.sum), 64'd3);
        rst_n = 1'b0;
        #1;
        check_val("rmf_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rmf_sum", 64'(bus.sum), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale++;
        end
        check_val("rmf_stale_beats", 64'(stale), 64'd0);
        run_vec("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

        // Random regression on the 16/4/4 and 64/8/2 builds
        for (int c = 0; c < 1200; c++) begin
            v  = (c < 1180) && ($urandom_range(0, 3) != 0);
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rb = ~ra;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            bus16.in_valid = v; bus16.a = ra[15:0]; bus16.b = rb[15:0]; bus16.cin = rc; bus16.sub = rs;
            bus64.in_valid = v; bus64.a = ra;       bus64.b = rb;       bus64.cin = rc; bus64.sub = rs;
            #1;
            if (q16.size() == 0) begin
                check_val("r16_spurious", 64'(bus16.out_valid), 64'd0);
            end else if (bus16.out_valid) begin
                e = q16.pop_front();
                check_val("r16_sum", 64'(bus16.sum), e[63:0]);
                check_val("r16_cout", 64'(bus16.cout), 64'(e[64]));
                check_val("r16_ovf", 64'(bus16.ovf), 64'(e[65]));
            end
            if (q64.size() == 0) begin
                check_val("r64_spurious", 64'(bus64.out_valid), 64'd0);
            end else if (bus64.out_valid) begin
                e = q64.pop_front();
                check_val("r64_sum", bus64.sum, e[63:0]);
                check_val("r64_cout", 64'(bus64.cout), 64'(e[64]));
                check_val("r64_ovf", 64'(bus64.ovf), 64'(e[65]));
            end
            if (v && bus16.in_ready) q16.push_back(ref_model(16, ra, rb, rc, rs));
            if (v && bus64.in_ready) q64.push_back(ref_model(64, ra, rb, rc, rs));
            @(posedge clk); #1;
        end
        check_val("r16_drained", 64'(q16.size()), 64'd0);
        check_val("r64_drained", 64'(q64.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
